// File: rtl/packet_scheduler.sv
// Data-island packet scheduler: buffers stereo audio pairs and arbitrates between
// audio, ACR, InfoFrame and null packets for each HDMI packet slot.
module packet_scheduler #(
    parameter int unsigned AUDIO_BIT_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned ACR_PERIOD      = 25200,
    parameter logic [7:0]  INFOFRAME_TYPE  = 8'h82
) (
    input  logic                                   clk_pixel,
    input  logic                                   reset,
    input  logic                                   frame_start,
    input  logic                                   packet_enable,
    input  logic                                   audio_sample_valid,
    input  logic [1:0][AUDIO_BIT_WIDTH-1:0]        audio_sample_word_in,
    output logic [7:0]                             packet_type,
    output logic [1:0][AUDIO_BIT_WIDTH-1:0]        audio_sample_word_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_level,
    output logic                                   overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CW = $clog2(ACR_PERIOD);

    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_NEAR = LW'(FIFO_DEPTH - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACR_PERIOD - 1);

    localparam logic [7:0] PKT_NULL  = 8'h00;
    localparam logic [7:0] PKT_ACR   = 8'h01;
    localparam logic [7:0] PKT_AUDIO = 8'h02;

    logic [1:0][AUDIO_BIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] acr_cnt;
    logic          acr_pending;
    logic          info_pending;

    logic          pop;
    logic          push;
    logic          drop;
    logic          full;
    logic          acr_wrap;
    logic [LW-1:0] level_next;
    logic          acr_next;
    logic          info_next;
    logic [7:0]    type_next;

    always_comb begin
        full     = (fifo_level == LVL_FULL);
        pop      = packet_enable && (packet_type == PKT_AUDIO) && (fifo_level != '0);
        push     = audio_sample_valid && (!full || pop);
        drop     = audio_sample_valid && full && !pop;
        acr_wrap = (acr_cnt == CNT_LAST);

        level_next = fifo_level;
        if (push && !pop)
            level_next = fifo_level + LW'(1);
        else if (pop && !push)
            level_next = fifo_level - LW'(1);

        // Timer/frame set wins over a same-edge consumption of the request.
        acr_next  = acr_wrap ||
                    (acr_pending && !(packet_enable && packet_type == PKT_ACR));
        info_next = frame_start ||
                    (info_pending && !(packet_enable && packet_type == INFOFRAME_TYPE));

        type_next = PKT_NULL;
        if (level_next >= LVL_NEAR)
            type_next = PKT_AUDIO;
        else if (acr_next)
            type_next = PKT_ACR;
        else if (info_next)
            type_next = INFOFRAME_TYPE;
        else if (level_next != '0)
            type_next = PKT_AUDIO;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            acr_cnt      <= '0;
            acr_pending  <= 1'b1;
            info_pending <= 1'b0;
            overflow     <= 1'b0;
            packet_type  <= PKT_NULL;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (drop)
                overflow <= 1'b1;
            acr_cnt      <= acr_wrap ? '0 : acr_cnt + CW'(1);
            fifo_level   <= level_next;
            acr_pending  <= acr_next;
            info_pending <= info_next;
            packet_type  <= type_next;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset && push)
            mem[wr_ptr] <= audio_sample_word_in;
    end

    assign audio_sample_word_out = (fifo_level == '0) ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed bench for packet_scheduler with a queue-based reference model
// compared every cycle, plus literal expectations on key events.
module tb_packet_scheduler;

    localparam int unsigned W    = 16;
    localparam int unsigned D    = 8;
    localparam int unsigned P    = 25200;
    localparam logic [7:0]  INFO = 8'h82;

    logic                 clk_pixel = 1'b0;
    logic                 reset = 1'b0;
    logic                 frame_start = 1'b0;
    logic                 packet_enable = 1'b0;
    logic                 audio_sample_valid = 1'b0;
    logic [1:0][W-1:0]    audio_sample_word_in = '0;
    logic [7:0]           packet_type;
    logic [1:0][W-1:0]    audio_sample_word_out;
    logic [3:0]           fifo_level;
    logic                 overflow;

    always #5 clk_pixel = ~clk_pixel;

    packet_scheduler #(
        .AUDIO_BIT_WIDTH(W),
        .FIFO_DEPTH(D),
        .ACR_PERIOD(P),
        .INFOFRAME_TYPE(INFO)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset(reset),
        .frame_start(frame_start),
        .packet_enable(packet_enable),
        .audio_sample_valid(audio_sample_valid),
        .audio_sample_word_in(audio_sample_word_in),
        .packet_type(packet_type),
        .audio_sample_word_out(audio_sample_word_out),
        .fifo_level(fifo_level),
        .overflow(overflow)
    );

    // Reference model: a queue of pairs, two request flags and a cycle counter.
    logic [31:0]  q[$];
    bit           m_acr, m_info, m_ovf, m_live;
    int unsigned  m_cnt;
    logic [7:0]   m_ptype;

    function automatic logic [7:0] pick(int unsigned lvl, bit acr, bit info);
        if (lvl >= D - 2) return 8'd2;
        if (acr)          return 8'd1;
        if (info)         return INFO;
        if (lvl > 0)      return 8'd2;
        return 8'd0;
    endfunction

    always @(posedge clk_pixel) begin : model
        bit popped;
        if (reset) begin
            q.delete();
            m_cnt   = 0;
            m_acr   = 1'b1;
            m_info  = 1'b0;
            m_ovf   = 1'b0;
            m_ptype = 8'd0;
            m_live  = 1'b1;
        end else if (m_live) begin
            popped = packet_enable && (m_ptype == 8'd2) && (q.size() > 0);
            if (popped) void'(q.pop_front());
            if (audio_sample_valid) begin
                if (q.size() < D) q.push_back(audio_sample_word_in);
                else              m_ovf = 1'b1;
            end
            if (packet_enable && m_ptype == 8'd1) m_acr = 1'b0;
            if (m_cnt == P - 1) begin
                m_cnt = 0;
                m_acr = 1'b1;
            end else begin
                m_cnt++;
            end
            if (packet_enable && m_ptype == INFO) m_info = 1'b0;
            if (frame_start) m_info = 1'b1;
            m_ptype = pick(q.size(), m_acr, m_info);
        end
    end

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        logic [31:0] head;
        @(posedge clk_pixel);
        #2;
        if (m_live) begin
            head = (q.size() > 0) ? q[0] : 32'h0;
            check("model_ptype", {24'h0, packet_type}, {24'h0, m_ptype});
            check("model_word",  audio_sample_word_out, head);
            check("model_level", {28'h0, fifo_level}, q.size());
            check("model_ovf",   {31'h0, overflow}, {31'h0, m_ovf});
        end
    endtask

    task automatic pulse_enable();
        repeat (32) tick();
        packet_enable = 1'b1;
        tick();
        packet_enable = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        audio_sample_valid   = 1'b1;
        audio_sample_word_in = w;
        tick();
        audio_sample_valid   = 1'b0;
    endtask

    initial begin : stim
        int n;

        // Reset state and first ACR request
        reset = 1'b1;
        tick();
        tick();
        check("rst_ptype", {24'h0, packet_type}, 32'h0);
        check("rst_level", {28'h0, fifo_level}, 32'h0);
        check("rst_word",  audio_sample_word_out, 32'h0);
        check("rst_ovf",   {31'h0, overflow}, 32'h0);
        reset = 1'b0;
        tick();
        n = 1;
        check("acr_after_reset", {24'h0, packet_type}, 32'h1);
        packet_enable = 1'b1;
        tick();
        packet_enable = 1'b0;
        n++;
        check("null_after_acr", {24'h0, packet_type}, 32'h0);
        while (packet_type != 8'd1 && n < 30000) begin
            tick();
            n++;
        end
        check("acr_period", n, P);
        pulse_enable();
        check("acr_consumed", {24'h0, packet_type}, 32'h0);

        // InfoFrame request and consumption
        repeat (4) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("info_pending", {24'h0, packet_type}, 32'h82);
        pulse_enable();
        check("info_consumed", {24'h0, packet_type}, 32'h0);

        // Three pairs drained in order
        push({16'h2222, 16'h1111});
        push({16'h4444, 16'h3333});
        push({16'h6666, 16'h5555});
        check("audio_type", {24'h0, packet_type}, 32'h2);
        check("head_left", {16'h0, audio_sample_word_out[0]}, 32'h1111);
        pulse_enable();
        check("pop1_word", audio_sample_word_out, 32'h4444_3333);
        pulse_enable();
        check("pop2_word", audio_sample_word_out, 32'h6666_5555);
        pulse_enable();
        check("pop3_level", {28'h0, fifo_level}, 32'h0);
        check("pop3_ptype", {24'h0, packet_type}, 32'h0);
        check("pop3_word",  audio_sample_word_out, 32'h0);

        // Overflow: nine pushes into eight slots
        for (int k = 0; k < 9; k++) push({16'hB000 + 16'(k), 16'hA000 + 16'(k)});
        check("ovf_level", {28'h0, fifo_level}, 32'h8);
        check("ovf_flag",  {31'h0, overflow}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            check("ovf_drain", audio_sample_word_out, {16'hB000 + 16'(k), 16'hA000 + 16'(k)});
            pulse_enable();
        end
        check("ovf_drained_level", {28'h0, fifo_level}, 32'h0);
        check("ovf_drained_word",  audio_sample_word_out, 32'h0);

        // Near-full audio outranks ACR, then ACR, then InfoFrame
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("rst2_ptype", {24'h0, packet_type}, 32'h1);
        check("rst2_ovf",   {31'h0, overflow}, 32'h0);
        for (int k = 0; k < 6; k++) push({16'hD000 + 16'(k), 16'hC000 + 16'(k)});
        check("nearfull_type", {24'h0, packet_type}, 32'h2);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("nearfull_vs_acr", {24'h0, packet_type}, 32'h2);
        pulse_enable();
        check("lvl5", {28'h0, fifo_level}, 32'h5);
        check("acr_at_lvl5", {24'h0, packet_type}, 32'h1);
        pulse_enable();
        check("info_after_acr", {24'h0, packet_type}, 32'h82);
        pulse_enable();
        check("audio_after_info", {24'h0, packet_type}, 32'h2);

        // Simultaneous push and pop while full
        for (int k = 6; k < 9; k++) push({16'hD000 + 16'(k), 16'hC000 + 16'(k)});
        check("full_level", {28'h0, fifo_level}, 32'h8);
        repeat (32) tick();
        packet_enable        = 1'b1;
        audio_sample_valid   = 1'b1;
        audio_sample_word_in = {16'hE0E0, 16'hF0F0};
        tick();
        packet_enable      = 1'b0;
        audio_sample_valid = 1'b0;
        check("pushpop_level", {28'h0, fifo_level}, 32'h8);
        check("pushpop_ovf",   {31'h0, overflow}, 32'h0);
        for (int k = 0; k < 7; k++) pulse_enable();
        check("pushpop_tail", audio_sample_word_out, 32'hE0E0_F0F0);

        // Reset mid-drain at level 4, with coincident enable and push ignored
        for (int k = 0; k < 3; k++) push({16'h7000 + 16'(k), 16'h8000 + 16'(k)});
        check("lvl4", {28'h0, fifo_level}, 32'h4);
        repeat (32) tick();
        reset              = 1'b1;
        packet_enable      = 1'b1;
        audio_sample_valid = 1'b1;
        tick();
        reset              = 1'b0;
        packet_enable      = 1'b0;
        audio_sample_valid = 1'b0;
        check("midrst_level", {28'h0, fifo_level}, 32'h0);
        check("midrst_word",  audio_sample_word_out, 32'h0);
        check("midrst_ptype", {24'h0, packet_type}, 32'h0);
        tick();
        check("midrst_acr", {24'h0, packet_type}, 32'h1);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
